// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch/jump flushes, data-memory waits.
// Optional build macro PIPE_PERF_CNT_EN adds saturating performance counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_RegWriteAddr,
  input  logic [4:0] IF_ID_Rs,
  input  logic [4:0] IF_ID_Rt,
  input  logic       ID_Jump,
  input  logic       EX_BranchTaken,
  input  logic       EX_MEM_MemRead,
  input  logic       EX_MEM_MemWrite,
  input  logic       mem_ready,
  output logic       PC_write,
  output logic       IF_ID_write,
  output logic       IF_ID_flush,
  output logic       ID_EX_flush,
  output logic       EX_MEM_write,
  output logic       MEM_WB_bubble,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0] perf_mem_stall,
  output logic [31:0] perf_loaduse,
  output logic [31:0] perf_flush,
`endif
  output logic       mem_err
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             mem_err_reg;

  logic memreq;
  logic memstall;
  logic loaduse;
  logic freeze;

  assign memreq   = EX_MEM_MemRead | EX_MEM_MemWrite;
  assign memstall = memreq & ~mem_ready;
  assign loaduse  = ID_EX_MemRead && (ID_EX_RegWriteAddr != 5'd0) &&
                    ((ID_EX_RegWriteAddr == IF_ID_Rs) || (ID_EX_RegWriteAddr == IF_ID_Rt));

  // MEM_WAIT holds the freeze until mem_ready, regardless of what sits in MEM.
  assign freeze = (state_reg == ERR) ||
                  ((state_reg == MEM_WAIT) && !mem_ready) ||
                  ((state_reg == RUN) && memstall);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= RUN;
      cnt_reg     <= '0;
      mem_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (memstall) begin
            state_reg <= MEM_WAIT;
            cnt_reg   <= CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          // A completion on the timeout cycle still counts as success.
          if (mem_ready) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_W'(MEM_TIMEOUT)) begin
            state_reg   <= ERR;
            mem_err_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ERR: begin
          mem_err_reg <= 1'b1;
        end
        default: begin
          state_reg <= RUN;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign mem_err = mem_err_reg;

  always_comb begin
    PC_write      = 1'b0;
    IF_ID_write   = 1'b0;
    IF_ID_flush   = 1'b0;
    ID_EX_flush   = 1'b0;
    EX_MEM_write  = 1'b0;
    MEM_WB_bubble = 1'b0;
    if (!reset) begin
      MEM_WB_bubble = 1'b0;
    end else if (freeze) begin
      MEM_WB_bubble = 1'b1;
    end else if (EX_BranchTaken) begin
      PC_write     = 1'b1;
      IF_ID_write  = 1'b1;
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      EX_MEM_write = 1'b1;
    end else if (loaduse) begin
      ID_EX_flush  = 1'b1;
      EX_MEM_write = 1'b1;
    end else if (ID_Jump) begin
      PC_write     = 1'b1;
      IF_ID_write  = 1'b1;
      IF_ID_flush  = 1'b1;
      EX_MEM_write = 1'b1;
    end else begin
      PC_write     = 1'b1;
      IF_ID_write  = 1'b1;
      EX_MEM_write = 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [2:0]  perf_inc;
  logic [31:0] perf_cnt_reg [3];

  // A bubble without an IF_ID flush can only be the load-use case.
  assign perf_inc[0] = MEM_WB_bubble & (state_reg != ERR);
  assign perf_inc[1] = ID_EX_flush & ~IF_ID_flush;
  assign perf_inc[2] = IF_ID_flush;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_perf
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          perf_cnt_reg[gi] <= '0;
        end else if (perf_inc[gi] && (perf_cnt_reg[gi] != 32'hFFFF_FFFF)) begin
          perf_cnt_reg[gi] <= perf_cnt_reg[gi] + 32'd1;
        end
      end
    end
  endgenerate

  assign perf_mem_stall = perf_cnt_reg[0];
  assign perf_loaduse   = perf_cnt_reg[1];
  assign perf_flush     = perf_cnt_reg[2];
`endif

endmodule
